// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the colour-bar frame generator and frame checker:
//   - default frame geometry (WIDTH, HEIGHT, NUMPIXELPLANES)
//   - colour-bar byte constants
//   - checker state enum (IDLE/RUN/HALT) and sample position struct
//   - CoreID constants
//   - helpers: expected bar byte, rowColCounter packing, saturating add
// -----------------------------------------------------------------------------
package frame_pkg;

  localparam int DEFAULT_WIDTH          = 1920;
  localparam int DEFAULT_HEIGHT         = 1080;
  localparam int DEFAULT_NUMPIXELPLANES = 3;

  localparam logic [7:0] BAR_ON  = 8'hFF;
  localparam logic [7:0] BAR_OFF = 8'h00;

  localparam logic [15:0] CHECKER_CORE_ID = 16'h0DEC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } checkerState_t;

  // Position of one sample in the frame.
  typedef struct packed {
    logic [2:0]  plane;
    logic [12:0] row;
    logic [12:0] col;
  } pixelPos_t;

  // Four vertical bars: red, green, blue, white.
  function automatic logic [7:0] barByte(input logic [2:0]  plane,
                                         input logic [12:0] col,
                                         input logic [12:0] quarter);
    logic [13:0] c;
    logic [13:0] q1;
    logic [13:0] q2;
    logic [13:0] q3;
    c  = {1'b0, col};
    q1 = {1'b0, quarter};
    q2 = q1 + q1;
    q3 = q2 + q1;
    if (c < q1)      barByte = (plane == 3'd0) ? BAR_ON : BAR_OFF;
    else if (c < q2) barByte = (plane == 3'd1) ? BAR_ON : BAR_OFF;
    else if (c < q3) barByte = (plane == 3'd2) ? BAR_ON : BAR_OFF;
    else             barByte = BAR_ON;
  endfunction

  // {3'b0, row, 3'b0, col}, the register-block view of a position.
  function automatic logic [31:0] packRowCol(input pixelPos_t pos);
    packRowCol = {3'b0, pos.row, 3'b0, pos.col};
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum    = {1'b0, a} + {1'b0, b};
    satAdd = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/frame_pattern_ref.sv
// -----------------------------------------------------------------------------
// frame_pattern_ref
// Single source of the colour-bar sample sequence. Holds the plane/col/row
// position of the next expected sample and produces the expected byte for
// every lane of the current beat (lane 0 = earliest sample).
// Ports:
//   clk, reset       clock, synchronous active-high reset (position -> 0)
//   advance          consume one beat: position moves by LANES samples
//   curPos           position of the next expected sample (lane 0)
//   lanePos          per-lane positions (only with FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN)
//   expectedBytes    expected byte per lane, lane i at [i*8 +: 8]
// -----------------------------------------------------------------------------
module frame_pattern_ref
  import frame_pkg::*;
#(
  parameter int LANES          = 1,
  parameter int NUMPIXELPLANES = DEFAULT_NUMPIXELPLANES,
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int HEIGHT         = DEFAULT_HEIGHT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   advance,
  output pixelPos_t              curPos,
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
  output pixelPos_t [LANES-1:0]  lanePos,
`endif
  output logic [LANES*8-1:0]     expectedBytes
);

  localparam logic [2:0]  LASTPLANE = 3'(NUMPIXELPLANES - 1);
  localparam logic [12:0] LASTCOL   = 13'(WIDTH - 1);
  localparam logic [12:0] LASTROW   = 13'(HEIGHT - 1);
  localparam logic [12:0] QUARTER   = 13'(WIDTH / 4);

  // Plane is the fastest index, then column, then row; each wraps to 0.
  function automatic pixelPos_t nextSample(input pixelPos_t pos);
    nextSample = pos;
    if (pos.plane == LASTPLANE) begin
      nextSample.plane = '0;
      if (pos.col == LASTCOL) begin
        nextSample.col = '0;
        nextSample.row = (pos.row == LASTROW) ? '0 : pos.row + 13'd1;
      end else begin
        nextSample.col = pos.col + 13'd1;
      end
    end else begin
      nextSample.plane = pos.plane + 3'd1;
    end
  endfunction

  pixelPos_t endPos;

  // Walk the lanes in order; the position after the last lane is where the
  // next beat starts.
  always_comb begin
    pixelPos_t walk;
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    walk          = curPos;
    expectedBytes = '0;
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
    lanePos       = '0;
`endif
    for (int lane = 0; lane < LANES; lane++) begin
      expectedBytes[lane*8 +: 8] = barByte(walk.plane, walk.col, QUARTER);
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
      lanePos[lane] = walk;
`endif
      walk = nextSample(walk);
    end
    endPos = walk;
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (reset)        curPos <= '0;
    else if (advance) curPos <= endPos;
  end

endmodule

// File: rtl/frame_checker_core.sv
// -----------------------------------------------------------------------------
// frame_checker_core
// Stream sink for the colour-bar generator. Regenerates the expected sample
// sequence, compares every accepted sample, and checks that `last` arrives on
// every (P+1)-th beat. Exposes saturating counters and state for the register
// block.
// Optional feature: define FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN to add the
// firstErrorPos / firstErrorData capture outputs.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   dataIn              DATAINWIDTHBYTES samples, lane 0 earliest
//   dataInValid/Last    beat valid, packet boundary marker
//   dataInReady         high in RUN unless clear is asserted
//   controlRegister     bit0 enable, bit1 clear, bit2 haltOnError
//   dataInLastPeriod    bits [24:0] = P
//   errorCount          mismatched samples (saturating)
//   lastErrorCount      misplaced or missing `last` (saturating)
//   beatCount           accepted beats (saturating)
//   rowColCounter       {3'b0,row,3'b0,col} of the next expected sample
//   status              IDLE=0, RUN=1, HALT=2
//   CoreID              16'h0DEC
//   firstErrorPos       {plane,row,3'b0,col} of first mismatch (optional)
//   firstErrorData      received byte of first mismatch (optional)
// -----------------------------------------------------------------------------
module frame_checker_core
  import frame_pkg::*;
#(
  parameter int DATAINWIDTHBYTES = 1,
  parameter int NUMPIXELPLANES   = DEFAULT_NUMPIXELPLANES,
  parameter int WIDTH            = DEFAULT_WIDTH,
  parameter int HEIGHT           = DEFAULT_HEIGHT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATAINWIDTHBYTES*8-1:0] dataIn,
  input  logic                          dataInValid,
  input  logic                          dataInLast,
  output logic                          dataInReady,
  input  logic [31:0]                   controlRegister,
  input  logic [31:0]                   dataInLastPeriod,
  output logic [31:0]                   errorCount,
  output logic [31:0]                   lastErrorCount,
  output logic [31:0]                   beatCount,
  output logic [31:0]                   rowColCounter,
  output logic [1:0]                    status,
  output logic [15:0]                   CoreID
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
  ,
  output logic [31:0]                   firstErrorPos,
  output logic [7:0]                    firstErrorData
`endif
);

  localparam int MCW = $clog2(DATAINWIDTHBYTES + 1);

  logic enable;
  logic clear;
  logic haltOnError;
  logic restart;
  logic [24:0] lastPeriod;
  logic unusedBits;

  assign enable      = controlRegister[0];
  assign clear       = controlRegister[1];
  assign haltOnError = controlRegister[2];
  assign lastPeriod  = dataInLastPeriod[24:0];
  assign unusedBits  = ^{controlRegister[31:3], dataInLastPeriod[31:25]};

  // Clear behaves exactly like reset for every piece of state.
  assign restart = reset | clear;

  checkerState_t state;
  checkerState_t nextState;
  logic          accept;

  // Gating with clear keeps a beat offered during clear from being counted.
  assign dataInReady = (state == RUN) && !restart;
  assign accept      = dataInValid && dataInReady;

  pixelPos_t                     curPos;
  logic [DATAINWIDTHBYTES*8-1:0] expectedBytes;
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
  pixelPos_t [DATAINWIDTHBYTES-1:0] lanePos;
`endif

  frame_pattern_ref #(
    .LANES          (DATAINWIDTHBYTES),
    .NUMPIXELPLANES (NUMPIXELPLANES),
    .WIDTH          (WIDTH),
    .HEIGHT         (HEIGHT)
  ) u_patternRef (
    .clk           (clk),
    .reset         (restart),
    .advance       (accept),
    .curPos        (curPos),
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
    .lanePos       (lanePos),
`endif
    .expectedBytes (expectedBytes)
  );

  // ---------------------------------------------------------------------------
  // Compare
  // ---------------------------------------------------------------------------
  logic [DATAINWIDTHBYTES-1:0] laneMismatch;
  logic [MCW-1:0]              mismatchCount;
  logic [24:0]                 beatIndex;
  logic                        expectedLast;
  logic                        sampleError;
  logic                        lastError;

  always_comb begin
    laneMismatch  = '0;
    mismatchCount = '0;
    for (int lane = 0; lane < DATAINWIDTHBYTES; lane++) begin
      laneMismatch[lane] = dataIn[lane*8 +: 8] != expectedBytes[lane*8 +: 8];
      mismatchCount      = mismatchCount + MCW'(laneMismatch[lane]);
    end
  end

  assign expectedLast = (beatIndex == lastPeriod);
  assign sampleError  = accept && (|laneMismatch);
  assign lastError    = accept && (dataInLast != expectedLast);

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (clear) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE: if (enable) nextState = RUN;
        // An error on the beat being accepted wins over enable dropping.
        RUN: begin
          if ((sampleError || lastError) && haltOnError) nextState = HALT;
          else if (!enable)                               nextState = IDLE;
        end
        HALT:    nextState = HALT;
        default: nextState = IDLE;
      endcase
    end
  end

  assign status = state;
  assign CoreID = CHECKER_CORE_ID;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (restart) begin
      errorCount     <= '0;
      lastErrorCount <= '0;
      beatCount      <= '0;
      beatIndex      <= '0;
    end else if (accept) begin
      errorCount     <= satAdd(errorCount, 32'(mismatchCount));
      lastErrorCount <= satAdd(lastErrorCount, {31'b0, lastError});
      beatCount      <= satAdd(beatCount, 32'd1);
      // Wrapping on >= keeps k bounded if P is lowered below the current k.
      beatIndex      <= (beatIndex >= lastPeriod) ? '0 : beatIndex + 25'd1;
    end
  end

  assign rowColCounter = packRowCol(curPos);

  // ---------------------------------------------------------------------------
  // First-error capture
  // ---------------------------------------------------------------------------
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
  logic       captured;
  pixelPos_t  firstLanePos;
  logic [7:0] firstLaneData;

  // Scan from the highest lane down so the earliest mismatching lane wins.
  always_comb begin
    firstLanePos  = '0;
    firstLaneData = '0;
    for (int lane = DATAINWIDTHBYTES - 1; lane >= 0; lane--) begin
      if (laneMismatch[lane]) begin
        firstLanePos  = lanePos[lane];
        firstLaneData = dataIn[lane*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      captured       <= 1'b0;
      firstErrorPos  <= '0;
      firstErrorData <= '0;
    end else if (sampleError && !captured) begin
      captured       <= 1'b1;
      firstErrorPos  <= packRowCol(firstLanePos) | {firstLanePos.plane, 29'b0};
      firstErrorData <= firstLaneData;
    end
  end
`else
  // Default build: no capture registers.
`endif

endmodule

// File: tb/tb_frame_checker_core.sv
module tb_frame_checker_core;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int NPL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dataIn;
  logic        dataInValid;
  logic        dataInLast;
  logic        dataInReady;
  logic [31:0] controlRegister;
  logic [31:0] dataInLastPeriod;
  logic [31:0] errorCount;
  logic [31:0] lastErrorCount;
  logic [31:0] beatCount;
  logic [31:0] rowColCounter;
  logic [1:0]  status;
  logic [15:0] CoreID;
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
  logic [31:0] firstErrorPos;
  logic [7:0]  firstErrorData;
`endif

  always #5 clk = ~clk;

  frame_checker_core #(
    .DATAINWIDTHBYTES (1),
    .NUMPIXELPLANES   (NPL),
    .WIDTH            (W),
    .HEIGHT           (H)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dataIn           (dataIn),
    .dataInValid      (dataInValid),
    .dataInLast       (dataInLast),
    .dataInReady      (dataInReady),
    .controlRegister  (controlRegister),
    .dataInLastPeriod (dataInLastPeriod),
    .errorCount       (errorCount),
    .lastErrorCount   (lastErrorCount),
    .beatCount        (beatCount),
    .rowColCounter    (rowColCounter),
    .status           (status),
    .CoreID           (CoreID)
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
    ,
    .firstErrorPos    (firstErrorPos),
    .firstErrorData   (firstErrorData)
`endif
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: positions come from the count of samples / beats accepted
  // since the last reset or clear, using plain division and modulo.
  // ---------------------------------------------------------------------------
  int          mSample;
  int          mBeat;
  int          mState;   // 0 idle, 1 run, 2 halt
  int          mP = 255;
  bit          mHlt = 1'b0;
  logic [31:0] mErr;
  logic [31:0] mLastErr;
  logic [31:0] mBeats;
  bit          mCaptured;
  logic [31:0] mFirstPos;
  logic [7:0]  mFirstData;
  bit          lastReady;

  function automatic logic [7:0] refByte(input int s);
    int p;
    int c;
    int q;
    p = s % NPL;
    c = (s / NPL) % W;
    q = W / 4;
    if (c < q)          return (p == 0) ? 8'hFF : 8'h00;
    else if (c < 2 * q) return (p == 1) ? 8'hFF : 8'h00;
    else if (c < 3 * q) return (p == 2) ? 8'hFF : 8'h00;
    else                return 8'hFF;
  endfunction

  function automatic logic [31:0] refPos(input int s);
    int pix;
    int col;
    int row;
    pix = s / NPL;
    col = pix % W;
    row = (pix / W) % H;
    return {3'b0, 13'(row), 3'b0, 13'(col)};
  endfunction

  function automatic bit refLast(input int b);
    return (b % (mP + 1)) == mP;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // One clock: drive at the falling edge, check ready before the rising edge,
  // check registered outputs at the next falling edge.
  task automatic cycle(input bit en, input bit clr, input bit hlt, input bit rst,
                       input bit v, input bit useData, input logic [7:0] fd,
                       input bit flipLast);
    logic [7:0] d;
    bit lst;
    bit mReady;
    bit acc;
    bit sErr;
    bit lErr;
    d   = useData ? fd : refByte(mSample);
    lst = refLast(mBeat) ^ flipLast;
    reset            = rst;
    controlRegister  = {29'b0, hlt, clr, en};
    dataInValid      = v;
    dataIn           = d;
    dataInLast       = lst;
    dataInLastPeriod = 32'(mP);
    #1;
    mReady    = (mState == 1) && !clr && !rst;
    lastReady = dataInReady;
    check("ready", {31'b0, dataInReady}, {31'b0, mReady});
    acc  = v && mReady;
    sErr = acc && (d != refByte(mSample));
    lErr = acc && (lst != refLast(mBeat));
    if (rst || clr) begin
      mSample = 0; mBeat = 0; mState = 0;
      mErr = '0; mLastErr = '0; mBeats = '0;
      mCaptured = 1'b0; mFirstPos = '0; mFirstData = '0;
    end else begin
      if (acc) begin
        if (sErr) mErr = bump(mErr);
        if (lErr) mLastErr = bump(mLastErr);
        mBeats = bump(mBeats);
        if (sErr && !mCaptured) begin
          mCaptured  = 1'b1;
          mFirstPos  = refPos(mSample) | (32'(mSample % NPL) << 29);
          mFirstData = d;
        end
        mSample++;
        mBeat++;
      end
      case (mState)
        0: if (en) mState = 1;
        1: if ((sErr || lErr) && hlt) mState = 2;
           else if (!en) mState = 0;
        default: mState = 2;
      endcase
    end
    @(negedge clk);
    check("errorCount", errorCount, mErr);
    check("lastErrorCount", lastErrorCount, mLastErr);
    check("beatCount", beatCount, mBeats);
    check("rowColCounter", rowColCounter, refPos(mSample));
    check("status", {30'b0, status}, 32'(mState));
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
    check("firstErrorPos", firstErrorPos, mFirstPos);
    check("firstErrorData", {24'b0, firstErrorData}, {24'b0, mFirstData});
`endif
  endtask

  task automatic startRun();
    cycle(1'b0, 1'b1, mHlt, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, mHlt, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic beat(input bit useData, input logic [7:0] fd, input bit flipLast);
    cycle(1'b1, 1'b0, mHlt, 1'b0, 1'b1, useData, fd, flipLast);
  endtask

  typedef struct {
    bit en;
    bit clr;
    bit hlt;
    bit v;
    bit bad;
    bit expReady;
    int expStatus;
    int expErr;
    int expBeats;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] fd;
    bit en;
    bit v;
    bit bad;
    bit fl;

    // en clr hlt v bad | ready status err beats
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 2};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2};

    mSample = 0; mBeat = 0; mState = 0;
    mErr = '0; mLastErr = '0; mBeats = '0;
    mCaptured = 1'b0; mFirstPos = '0; mFirstData = '0;

    // Reset values.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check("reset_ready", {31'b0, lastReady}, 32'd0);
    check("reset_status", {30'b0, status}, 32'd0);
    check("reset_beats", beatCount, 32'd0);
    check("reset_rowcol", rowColCounter, 32'd0);
    check("core_id", {16'b0, CoreID}, 32'h0000_0DEC);

    // Table-driven FSM / accept sequence.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      fd = refByte(mSample) ^ 8'h5A;
      cycle(vecs[i].en, vecs[i].clr, vecs[i].hlt, 1'b0, vecs[i].v, vecs[i].bad, fd, 1'b0);
      check($sformatf("vec%0d_ready", i), {31'b0, lastReady}, {31'b0, vecs[i].expReady});
      check($sformatf("vec%0d_status", i), {30'b0, status}, 32'(vecs[i].expStatus));
      check($sformatf("vec%0d_err", i), errorCount, 32'(vecs[i].expErr));
      check($sformatf("vec%0d_beats", i), beatCount, 32'(vecs[i].expBeats));
    end

    // Clean stream, three full rows.
    mP = 255; mHlt = 1'b0;
    startRun();
    for (int i = 0; i < 144; i++) beat(1'b0, 8'h00, 1'b0);
    check("clean_err", errorCount, 32'd0);
    check("clean_lasterr", lastErrorCount, 32'd0);
    check("clean_beats", beatCount, 32'd144);
    check("clean_rowcol", rowColCounter, 32'h0003_0000);

    // Byte 5 (plane 2, col 1) corrupted to 7F, later byte 7 corrupted too.
    startRun();
    for (int i = 0; i < 9; i++) begin
      if (i == 5)      beat(1'b1, 8'h7F, 1'b0);
      else if (i == 7) beat(1'b1, 8'h11, 1'b0);
      else             beat(1'b0, 8'h00, 1'b0);
      if (i == 5) begin
        check("flip_err", errorCount, 32'd1);
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
        check("flip_pos", firstErrorPos, 32'h4000_0001);
        check("flip_data", {24'b0, firstErrorData}, 32'h0000_007F);
`endif
      end
    end
    check("flip_err_total", errorCount, 32'd2);
`ifdef FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN
    check("flip_pos_held", firstErrorPos, 32'h4000_0001);
`endif

    // P=3, last driven on beat 2 instead of beat 3.
    mP = 3;
    startRun();
    for (int i = 0; i < 12; i++) begin
      beat(1'b0, 8'h00, (i == 2) || (i == 3));
      if (i == 3) check("last_err_b3", lastErrorCount, 32'd2);
    end
    check("last_err_final", lastErrorCount, 32'd2);

    // Halt on error at beat 10, then clear and restart.
    mP = 255; mHlt = 1'b1;
    startRun();
    for (int i = 0; i < 11; i++) beat(i == 10, refByte(mSample) ^ 8'h01, 1'b0);
    check("halt_status", {30'b0, status}, 32'd2);
    beat(1'b0, 8'h00, 1'b0);
    check("halt_ready", {31'b0, lastReady}, 32'd0);
    check("halt_beats", beatCount, 32'd11);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("halt_clr_status", {30'b0, status}, 32'd0);
    check("halt_clr_err", errorCount, 32'd0);
    check("halt_clr_beats", beatCount, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("halt_reen_status", {30'b0, status}, 32'd1);
    beat(1'b1, 8'hFF, 1'b0);
    check("halt_pos0_err", errorCount, 32'd0);
    check("halt_pos0_beats", beatCount, 32'd1);
    mHlt = 1'b0;

    // Valid held high while enable drops mid-row.
    startRun();
    for (int i = 0; i < 7; i++) beat(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("endrop_ready", {31'b0, lastReady}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("endrop_idle_ready", {31'b0, lastReady}, 32'd0);
    end
    beat(1'b0, 8'h00, 1'b0);
    check("endrop_reen_ready", {31'b0, lastReady}, 32'd0);
    for (int i = 0; i < 10; i++) beat(1'b0, 8'h00, 1'b0);
    check("endrop_err", errorCount, 32'd0);
    check("endrop_beats", beatCount, 32'd18);
    check("endrop_rowcol", rowColCounter, 32'h0000_0006);

    // Saturation from a preloaded counter.
    startRun();
    force dut.errorCount = 32'hFFFF_FFFD;
    #1;
    release dut.errorCount;
    mErr = 32'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) beat(1'b1, refByte(mSample) ^ 8'h80, 1'b0);
    check("sat_err", errorCount, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    mP = 5;
    startRun();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        mP   = $urandom_range(0, 7);
        mHlt = ($urandom_range(0, 3) == 0);
        cycle(1'b1, 1'b1, mHlt, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      end else if ($urandom_range(0, 199) == 0) begin
        cycle(1'b1, 1'b0, mHlt, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      end else begin
        en  = ($urandom_range(0, 15) != 0);
        v   = ($urandom_range(0, 3) != 0);
        bad = ($urandom_range(0, 11) == 0);
        fl  = ($urandom_range(0, 19) == 0);
        fd  = refByte(mSample) ^ 8'($urandom_range(1, 255));
        cycle(en, 1'b0, mHlt, 1'b0, v, bad, fd, fl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/frame_checker_core.md
# frame_checker_core

Stream sink that consumes the colour-bar video stream from the frame generator and checks it. It accepts beats on a valid/ready/last interface, regenerates the expected sample sequence internally, compares every sample, and checks that `last` sits exactly on the programmed period. Counters and status are exposed for the AXI-Lite register block, alongside the generator's registers.

## Interface
Parameters:
- `DATAINWIDTHBYTES`, 1: samples per beat; lane 0 is the earliest sample.
- `NUMPIXELPLANES`, 3: samples per pixel (R, G, B).
- `WIDTH`, 1920: pixels per row.
- `HEIGHT`, 1080: rows per frame.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `dataIn` in `DATAINWIDTHBYTES*8`: sample data.
- `dataInValid` in 1: beat valid.
- `dataInLast` in 1: packet boundary marker.
- `dataInReady` out 1: sink can accept a beat.
- `controlRegister` in 32: bit0 = enable, bit1 = clear, bit2 = haltOnError.
- `dataInLastPeriod` in 32: bits [24:0] = P. `last` is expected on every (P+1)-th beat.
- `errorCount` out 32: count of mismatched samples.
- `lastErrorCount` out 32: count of misplaced or missing `last`.
- `beatCount` out 32: count of accepted beats.
- `rowColCounter` out 32: {3'b0, row[12:0], 3'b0, col[12:0]}, the expected position of the next sample.
- `status` out 2: state encoding.
- `CoreID` out 16: constant 16'h0DEC.

## Operation
- A beat is accepted when `dataInValid && dataInReady`.
- `dataInReady` = (state == RUN).
- States:
  - IDLE (0): the only exit is enable=1, which moves to RUN.
  - RUN (1): enable=0 returns to IDLE. Any error while haltOnError=1 moves to HALT.
  - HALT (2): only clear or reset leaves HALT, and both go to IDLE.
- Clear (bit1=1), held any number of cycles, acts like reset:
  - all counters go to 0 and the state goes to IDLE;
  - `dataInReady` is 0 in the same cycle clear is sampled.
- Expected sample for plane p at column c, with Q = WIDTH/4:
  - c < Q: FF if p==0, else 00.
  - c < 2Q: FF if p==1, else 00.
  - c < 3Q: FF if p==2, else 00.
  - otherwise: FF.
- Position advance per sample (lanes processed in order within a beat):
  - plane increments modulo NUMPIXELPLANES;
  - on plane wrap, col increments modulo WIDTH;
  - on col wrap, row increments modulo HEIGHT.
- Each mismatching lane adds 1 to `errorCount`. Several lanes can add in the same beat.
- Last check:
  - a beat index counter k runs 0..P and wraps to 0 after P;
  - expected `last` = (k == P);
  - any accepted beat where `dataInLast` differs from expected adds 1 to `lastErrorCount`.
- All 32-bit counters saturate at 32'hFFFF_FFFF and never wrap.
- Changing P mid-stream takes effect on the next compare. k is not reset when P changes.

## Timing
- Reset values: every counter 0, `status`=0, `dataInReady`=0, position (plane, col, row) = 0, k=0.
- Compare is combinational on the accepted beat. Counters, position and state update on the following clock edge, giving 1-cycle visibility latency.
- The HALT transition happens at the same edge as the error count update. `dataInReady` is 0 from the next cycle on.
- Enable falling while `dataInValid` is high:
  - the beat in that cycle is still accepted (ready was 1);
  - ready is 0 from the next cycle on.
- Reset or clear mid-frame discards position. The next accepted beat is checked as row 0, col 0, plane 0, k=0.
- Back-to-back beats at full throughput: one beat per clock in RUN, with no bubbles inserted.

## Configuration
- `FRAME_CHECKER_FIRST_ERROR_CAPTURE_EN`:
  - defined: adds outputs `firstErrorPos` (32 bits, `rowColCounter` format plus plane in bits [31:29]) and `firstErrorData` (8 bits, the received byte). Both latch on the first sample mismatch after reset/clear and hold until the next reset/clear.
  - undefined: these ports and registers are absent and there is no other change.

## Structure
- Package `frame_pkg`:
  - geometry defaults (WIDTH, HEIGHT, NUMPIXELPLANES);
  - colour-bar byte constants (8'hFF / 8'h00);
  - the state enum (IDLE/RUN/HALT);
  - CoreID constants, shared with the generator.
- Sub-module `frame_pattern_ref`: holds the plane/col/row counters and the per-lane expected-byte function, so the checker and any future generator rewrite share one pattern source.

## Test plan
- Clean stream, P=255, 3 full rows of WIDTH=16 (configured via parameter) → `errorCount`=0, `lastErrorCount`=0, `beatCount`=144, `rowColCounter`=row 3 col 0.
- Flip byte 5 to 8'h7F (plane 2, col 1) → `errorCount`=1 one cycle after acceptance. With the capture macro defined, `firstErrorPos` = plane 2, row 0, col 1 and `firstErrorData` = 8'h7F.
- P=3, drive `last` on beat 2 instead of beat 3 → `lastErrorCount`=2 (missing on beat 3, extra on beat 2). Beats 7, 11 correct → no further increment.
- haltOnError=1, inject an error on beat 10 → `status`=2 and `dataInReady`=0 from cycle after beat 10. Pulse clear → `status`=0, counters 0. Enable → RUN, and the next beat is checked as position 0.
- Valid held high with enable toggled 1→0 mid-row → exactly the beat in the falling cycle is accepted. The stream resumes on re-enable with no position slip and `errorCount`=0.
- Force `errorCount` near saturation (inject 2^32 errors via a backdoor-preloaded counter) → the count holds at 32'hFFFF_FFFF.
